// File: rtl/intcode_pkg.sv
// Shared types and constants for the intcode loader.
//   word_t          : one intcode word (two's complement)
//   loader_state_e  : parser state (IDLE, NUMBER, DONE, ERROR)
//   CH_*            : ASCII codes the parser recognises
//   is_digit()      : true for '0'..'9'
package intcode_pkg;

  localparam int WORD_W = 64;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NUMBER = 2'd1,
    DONE   = 2'd2,
    ERROR  = 2'd3
  } loader_state_e;

  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_NINE  = 8'h39;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_ZERO) && (c <= CH_NINE);
  endfunction

endpackage

// File: rtl/intcode_loader_if.sv
// Byte-stream input and program-write output bundle of the intcode loader.
//   master : stream source / program consumer (drives bytes, patch values)
//   slave  : the loader (drives in_ready and the write/status outputs)
// Signals: in_valid/in_ready/in_byte/in_last byte handshake, patch_en/noun/verb
// patch controls, write_program/data word pulse, word_count/done/error status.
interface intcode_loader_if
  import intcode_pkg::*;
#(
  parameter int WORD_W    = 64,
  parameter int MAX_WORDS = 4096,
  parameter int COUNT_W   = $clog2(MAX_WORDS + 1)
);

  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_byte;
  logic               in_last;
  logic               patch_en;
  logic [WORD_W-1:0]  noun;
  logic [WORD_W-1:0]  verb;
  logic               write_program;
  logic [WORD_W-1:0]  data;
  logic [COUNT_W-1:0] word_count;
  logic               done;
  logic               error;

  modport master (
    output in_valid, in_byte, in_last, patch_en, noun, verb,
    input  in_ready, write_program, data, word_count, done, error
  );

  modport slave (
    input  in_valid, in_byte, in_last, patch_en, noun, verb,
    output in_ready, write_program, data, word_count, done, error
  );

endinterface

// File: rtl/intcode_dec_accum.sv
// Combinational decimal accumulate step: o_next = i_acc*10 + i_digit.
//   i_acc   : current magnitude
//   i_digit : decimal digit 0..9
//   i_neg   : magnitude belongs to a negative number (limit is one larger)
//   o_next  : new magnitude (valid when o_ovf = 0)
//   o_ovf   : new magnitude exceeds the representable range for the sign
module intcode_dec_accum #(
  parameter int WORD_W = 64
) (
  input  logic [WORD_W-1:0] i_acc,
  input  logic [3:0]        i_digit,
  input  logic              i_neg,
  output logic [WORD_W-1:0] o_next,
  output logic              o_ovf
);

  // Four guard bits hold acc*10+9 for any acc below 2^WORD_W.
  localparam logic [WORD_W+3:0] LIM_POS = {5'b0, {(WORD_W-1){1'b1}}};
  localparam logic [WORD_W+3:0] LIM_NEG = {4'b0, 1'b1, {(WORD_W-1){1'b0}}};

  logic [WORD_W+3:0] w_ext;
  logic [WORD_W+3:0] w_sum;
  logic [WORD_W+3:0] w_limit;

  assign w_ext   = {4'b0, i_acc};
  assign w_sum   = (w_ext << 3) + (w_ext << 1) + {{WORD_W{1'b0}}, i_digit};
  assign w_limit = i_neg ? LIM_NEG : LIM_POS;
  assign o_ovf   = (w_sum > w_limit);
  assign o_next  = w_sum[WORD_W-1:0];

endmodule

// File: rtl/intcode_loader.sv
// Parses an ASCII stream of comma-separated decimal integers into program
// words and writes them to intcode one word per write_program pulse.
//   clk    : clock
//   reset  : asynchronous active-high reset
//   bus    : intcode_loader_if.slave
//            in_valid/in_ready/in_byte/in_last - byte stream in
//            patch_en/noun/verb                - overrides for words 1 and 2
//            write_program/data                - one-cycle word pulse out
//            word_count/done/error             - status (done/error sticky)
module intcode_loader
  import intcode_pkg::*;
#(
  parameter int WORD_W    = 64,
  parameter int MAX_WORDS = 4096,
  parameter int COUNT_W   = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  intcode_loader_if.slave   bus
);

  localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_WORDS);
  localparam logic [COUNT_W-1:0] IDX_NOUN = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] IDX_VERB = COUNT_W'(2);

  loader_state_e      r_state;
  logic [WORD_W-1:0]  r_acc;
  logic               r_neg;
  logic               r_have;
  logic               r_wp;
  logic [WORD_W-1:0]  r_data;
  logic [COUNT_W-1:0] r_count;
  logic               r_done;
  logic               r_error;

  logic              w_active;
  logic              w_xfer;
  logic              w_digit;
  logic              w_minus;
  logic              w_comma;
  logic              w_nl;
  logic              w_blank;
  logic              w_bad_char;
  logic              w_bad_minus;
  logic [WORD_W-1:0] w_next_acc;
  logic              w_ovf;
  logic [WORD_W-1:0] w_cur_acc;
  logic              w_cur_neg;
  logic              w_cur_have;
  logic              w_end;
  logic              w_term;
  logic              w_emit;
  logic              w_err;
  logic [WORD_W-1:0] w_value;

  function automatic logic [WORD_W-1:0] patch_word(
    input logic [COUNT_W-1:0] idx,
    input logic               en,
    input logic [WORD_W-1:0]  parsed,
    input logic [WORD_W-1:0]  noun_v,
    input logic [WORD_W-1:0]  verb_v
  );
    if (en && idx == IDX_NOUN) return noun_v;
    if (en && idx == IDX_VERB) return verb_v;
    return parsed;
  endfunction

  intcode_dec_accum #(.WORD_W(WORD_W)) u_accum (
    .i_acc   (r_acc),
    .i_digit (bus.in_byte[3:0]),
    .i_neg   (r_neg),
    .o_next  (w_next_acc),
    .o_ovf   (w_ovf)
  );

  assign w_active = (r_state == IDLE) || (r_state == NUMBER);
  assign w_xfer   = bus.in_valid && w_active;

  assign w_digit    = is_digit(bus.in_byte);
  assign w_minus    = (bus.in_byte == CH_MINUS);
  assign w_comma    = (bus.in_byte == CH_COMMA);
  assign w_nl       = (bus.in_byte == CH_NL);
  assign w_blank    = (bus.in_byte == CH_SPACE) || (bus.in_byte == CH_CR);
  assign w_bad_char = !(w_digit || w_minus || w_comma || w_nl || w_blank);
  // A sign is only allowed once, before any digit of the field.
  assign w_bad_minus = w_minus && (r_have || r_neg);

  // Field state as it stands after this byte, before any terminator clears it.
  assign w_cur_acc  = w_digit ? w_next_acc : r_acc;
  assign w_cur_neg  = r_neg || w_minus;
  assign w_cur_have = r_have || w_digit;

  assign w_end  = w_nl || bus.in_last;
  assign w_term = w_comma || w_end;
  assign w_emit = w_term && w_cur_have;

  assign w_err = w_bad_char
              || w_bad_minus
              || (w_digit && w_ovf)
              || (w_comma && !r_have)
              || (w_term && w_cur_neg && !w_cur_have)
              || (w_emit && (r_count == MAX_CNT));

  assign w_value = w_cur_neg ? (~w_cur_acc + 1'b1) : w_cur_acc;

  assign bus.in_ready      = w_active;
  assign bus.write_program = r_wp;
  assign bus.data          = r_data;
  assign bus.word_count    = r_count;
  assign bus.done          = r_done;
  assign bus.error         = r_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_neg   <= 1'b0;
      r_have  <= 1'b0;
      r_wp    <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_wp <= 1'b0;
      if (w_xfer) begin
        if (w_err) begin
          r_state <= ERROR;
          r_error <= 1'b1;
        end else begin
          if (w_emit) begin
            r_wp    <= 1'b1;
            r_data  <= patch_word(r_count, bus.patch_en, w_value, bus.noun, bus.verb);
            r_count <= r_count + COUNT_W'(1);
          end
          // Clearing on the terminator lets the next field's digit follow directly.
          if (w_term) begin
            r_acc  <= '0;
            r_neg  <= 1'b0;
            r_have <= 1'b0;
          end else begin
            r_acc  <= w_cur_acc;
            r_neg  <= w_cur_neg;
            r_have <= w_cur_have;
          end
          if (w_end) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (w_comma) begin
            r_state <= IDLE;
          end else if (w_cur_have) begin
            r_state <= NUMBER;
          end else begin
            r_state <= IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_intcode_loader.sv
// Directed bench for intcode_loader: byte strings with hand-computed words.
module tb_intcode_loader;
  import intcode_pkg::*;

  logic clk;
  logic reset;

  int n_total = 0;
  int n_bad   = 0;

  logic [63:0] q_data[$];
  logic        q_done[$];
  logic [63:0] ev[8];

  intcode_loader_if #(.WORD_W(64), .MAX_WORDS(4096)) bus ();

  intcode_loader #(.WORD_W(64), .MAX_WORDS(4096)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.write_program === 1'b1) begin
      q_data.push_back(bus.data);
      q_done.push_back(bus.done);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_last  = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input logic last_on_final);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], last_on_final && (i == s.len() - 1));
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q_data.delete();
    q_done.delete();
  endtask

  task automatic check_words(input string tag, input int n);
    chk({tag, "_npulse"}, 64'(q_data.size()), 64'(n));
    for (int i = 0; i < n; i++)
      if (i < q_data.size())
        chk($sformatf("%s_w%0d", tag, i), q_data[i], ev[i]);
  endtask

  task automatic check_status(input string tag, input int cnt, input logic d, input logic e);
    chk({tag, "_count"}, 64'(bus.word_count), 64'(cnt));
    chk({tag, "_done"},  64'(bus.done),  64'(d));
    chk({tag, "_error"}, 64'(bus.error), 64'(e));
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    bus.in_last  = 1'b0;
    bus.patch_en = 1'b0;
    bus.noun     = 64'd0;
    bus.verb     = 64'd0;
    #12;
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_wp",    64'(bus.write_program), 64'd0);
    chk("rst_data",  bus.data, 64'd0);
    check_status("rst", 0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Plain program terminated by newline
    do_reset();
    send_str("1,0,0,3,99\n", 1'b0);
    ev = '{64'd1, 64'd0, 64'd0, 64'd3, 64'd99, 64'd0, 64'd0, 64'd0};
    check_words("plain", 5);
    check_status("plain", 5, 1'b1, 1'b0);
    chk("plain_ready", 64'(bus.in_ready), 64'd0);
    if (q_done.size() == 5) begin
      chk("plain_done_w3", 64'(q_done[3]), 64'd0);
      chk("plain_done_w4", 64'(q_done[4]), 64'd1);
    end

    // Patched noun/verb, last flagged on the final digit
    do_reset();
    bus.patch_en = 1'b1;
    bus.noun     = 64'd12;
    bus.verb     = 64'd2;
    send_str("1,0,0,3,99", 1'b1);
    bus.patch_en = 1'b0;
    ev = '{64'd1, 64'd12, 64'd2, 64'd3, 64'd99, 64'd0, 64'd0, 64'd0};
    check_words("patch", 5);
    check_status("patch", 5, 1'b1, 1'b0);

    // Negative value and blanks
    do_reset();
    send_str("-7, 42 \r\n", 1'b0);
    ev[0] = 64'hFFFF_FFFF_FFFF_FFF9;
    ev[1] = 64'd42;
    check_words("neg", 2);
    check_status("neg", 2, 1'b1, 1'b0);

    // Empty field
    do_reset();
    send_str("1,,2\n", 1'b0);
    ev[0] = 64'd1;
    check_words("dblcomma", 1);
    check_status("dblcomma", 1, 1'b0, 1'b1);
    chk("dblcomma_ready", 64'(bus.in_ready), 64'd0);

    // 2^63 overflows as a positive number
    do_reset();
    send_str("9223372036854775808\n", 1'b0);
    check_words("ovf", 0);
    check_status("ovf", 0, 1'b0, 1'b1);

    // -2^63 is the most negative word
    do_reset();
    send_str("-9223372036854775808\n", 1'b0);
    ev[0] = 64'h8000_0000_0000_0000;
    check_words("minint", 1);
    check_status("minint", 1, 1'b1, 1'b0);

    // Malformed inputs
    do_reset();
    send_str("5x\n", 1'b0);
    check_words("badch", 0);
    check_status("badch", 0, 1'b0, 1'b1);
    do_reset();
    send_str("-\n", 1'b0);
    check_words("lonemin", 0);
    check_status("lonemin", 0, 1'b0, 1'b1);
    do_reset();
    send_str(",5\n", 1'b0);
    check_words("leadcomma", 0);
    check_status("leadcomma", 0, 1'b0, 1'b1);
    do_reset();
    send_str("3-\n", 1'b0);
    check_words("latemin", 0);
    check_status("latemin", 0, 1'b0, 1'b1);

    // Empty stream
    do_reset();
    send_str("\n", 1'b0);
    check_words("empty", 0);
    check_status("empty", 0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a field
    do_reset();
    send_str("123,4", 1'b0);
    ev[0] = 64'd123;
    check_words("prerst", 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_wp",    64'(bus.write_program), 64'd0);
    chk("midrst_data",  bus.data, 64'd0);
    chk("midrst_ready", 64'(bus.in_ready), 64'd1);
    check_status("midrst", 0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    q_data.delete();
    q_done.delete();
    send_str("7\n", 1'b0);
    ev[0] = 64'd7;
    check_words("postrst", 1);
    check_status("postrst", 1, 1'b1, 1'b0);

    // One word beyond MAX_WORDS
    do_reset();
    for (int i = 0; i < 4096; i++) begin
      send_byte(CH_ZERO, 1'b0);
      send_byte(CH_COMMA, 1'b0);
    end
    send_str("5\n", 1'b0);
    chk("maxw_npulse", 64'(q_data.size()), 64'd4096);
    if (q_data.size() > 0)
      chk("maxw_last", q_data[q_data.size() - 1], 64'd0);
    check_status("maxw", 4096, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
